// File: rtl/copro_fifo_port.sv
// Coprocessor-side endpoint for the HPS<->FPGA Avalon-MM FIFO pair. It pops command words from the
// HPS FIFO into an RX buffer that feeds the accelerator, and collects result words in a TX buffer
// that drains into the FIFO back to the HPS. It also produces a packed status word.
module copro_fifo_port #(
    parameter int unsigned RX_DEPTH = 4,
    parameter int unsigned TX_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    // Read master on fifo_to_copro_out
    output logic        avm_rd_read,
    input  logic        avm_rd_waitrequest,
    input  logic [63:0] avm_rd_readdata,
    // Write master on fifo_to_hps_in
    output logic        avm_wr_write,
    input  logic        avm_wr_waitrequest,
    output logic [63:0] avm_wr_writedata,
    // Accelerator command stream
    output logic [63:0] cmd_data,
    output logic        cmd_valid,
    input  logic        cmd_ready,
    // Accelerator result stream
    input  logic [63:0] rsp_data,
    input  logic        rsp_valid,
    output logic        rsp_ready,
    // Control and status
    input  logic        enable,
    input  logic        rx_flush,
    output logic [31:0] status
);

    localparam int unsigned RxPtrW = $clog2(RX_DEPTH);
    localparam int unsigned RxCntW = RxPtrW + 1;
    localparam int unsigned TxPtrW = $clog2(TX_DEPTH);
    localparam int unsigned TxCntW = TxPtrW + 1;
    localparam logic [RxCntW-1:0] RxFull = RxCntW'(RX_DEPTH);
    localparam logic [TxCntW-1:0] TxFull = TxCntW'(TX_DEPTH);

    typedef enum logic {
        RdIdle,
        RdReq
    } rd_state_e;

    rd_state_e         rd_state_q, rd_state_d;
    // Set when a flush hits while a read is outstanding; that read's word must be dropped.
    logic              rd_drop_q, rd_drop_d;

    logic [RxPtrW-1:0] rx_wr_ptr_q, rx_wr_ptr_d;
    logic [RxPtrW-1:0] rx_rd_ptr_q, rx_rd_ptr_d;
    logic [RxCntW-1:0] rx_cnt_q, rx_cnt_d;
    logic [RxCntW-1:0] rx_next;
    logic [63:0]       rx_mem_q [RX_DEPTH];

    logic [TxPtrW-1:0] tx_wr_ptr_q, tx_wr_ptr_d;
    logic [TxPtrW-1:0] tx_rd_ptr_q, tx_rd_ptr_d;
    logic [TxCntW-1:0] tx_cnt_q, tx_cnt_d;
    logic [63:0]       tx_mem_q [TX_DEPTH];

    logic [7:0]        rd_total_q, rd_total_d;
    logic [7:0]        wr_total_q, wr_total_d;

    logic rd_accept, rx_push, rx_pop, rd_more;
    logic tx_push, tx_pop;

    assign rd_accept = (rd_state_q == RdReq) && !avm_rd_waitrequest;
    assign rx_push   = rd_accept && !rx_flush && !rd_drop_q;
    assign rx_pop    = cmd_valid && cmd_ready;
    assign rx_next   = rx_cnt_q + RxCntW'(rx_push) - RxCntW'(rx_pop);
    // Issuing a read reserves one RX slot, so only ask when one will be free after this cycle.
    assign rd_more   = enable && !rx_flush && (rx_next < RxFull);

    assign tx_push   = rsp_valid && rsp_ready;
    assign tx_pop    = avm_wr_write && !avm_wr_waitrequest;

    // Outputs: head entries are masked to zero while their buffer is empty.
    assign avm_rd_read      = (rd_state_q == RdReq);
    assign cmd_valid        = (rx_cnt_q != '0);
    assign cmd_data         = cmd_valid ? rx_mem_q[rx_rd_ptr_q] : 64'h0;
    assign rsp_ready        = (tx_cnt_q < TxFull);
    assign avm_wr_write     = (tx_cnt_q != '0);
    assign avm_wr_writedata = avm_wr_write ? tx_mem_q[tx_rd_ptr_q] : 64'h0;
    assign status           = {wr_total_q, rd_total_q, 8'(tx_cnt_q), 8'(rx_cnt_q)};

    // Read engine next state; an issued read is held until accepted.
    always_comb begin
        rd_state_d = rd_state_q;
        rd_drop_d  = rd_drop_q;
        case (rd_state_q)
            RdIdle: if (rd_more) rd_state_d = RdReq;
            RdReq:  if (rd_accept) rd_state_d = rd_more ? RdReq : RdIdle;
            default: rd_state_d = RdIdle;
        endcase
        if (rd_accept) begin
            rd_drop_d = 1'b0;
        end else if (rx_flush && (rd_state_q == RdReq)) begin
            rd_drop_d = 1'b1;
        end
    end

    // RX buffer pointers and occupancy; flush wins over push and pop.
    always_comb begin
        rx_wr_ptr_d = rx_wr_ptr_q;
        rx_rd_ptr_d = rx_rd_ptr_q;
        rx_cnt_d    = rx_next;
        if (rx_flush) begin
            rx_wr_ptr_d = '0;
            rx_rd_ptr_d = '0;
            rx_cnt_d    = '0;
        end else begin
            if (rx_push) rx_wr_ptr_d = rx_wr_ptr_q + RxPtrW'(1);
            if (rx_pop)  rx_rd_ptr_d = rx_rd_ptr_q + RxPtrW'(1);
        end
    end

    // TX buffer pointers, occupancy and traffic counters.
    always_comb begin
        tx_wr_ptr_d = tx_wr_ptr_q;
        tx_rd_ptr_d = tx_rd_ptr_q;
        tx_cnt_d    = tx_cnt_q + TxCntW'(tx_push) - TxCntW'(tx_pop);
        if (tx_push) tx_wr_ptr_d = tx_wr_ptr_q + TxPtrW'(1);
        if (tx_pop)  tx_rd_ptr_d = tx_rd_ptr_q + TxPtrW'(1);
        rd_total_d = rd_total_q + 8'(rd_accept);
        wr_total_d = wr_total_q + 8'(tx_pop);
    end

    // Control state registers with asynchronous reset.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rd_state_q  <= RdIdle;
            rd_drop_q   <= 1'b0;
            rx_wr_ptr_q <= '0;
            rx_rd_ptr_q <= '0;
            rx_cnt_q    <= '0;
            tx_wr_ptr_q <= '0;
            tx_rd_ptr_q <= '0;
            tx_cnt_q    <= '0;
            rd_total_q  <= '0;
            wr_total_q  <= '0;
        end else begin
            rd_state_q  <= rd_state_d;
            rd_drop_q   <= rd_drop_d;
            rx_wr_ptr_q <= rx_wr_ptr_d;
            rx_rd_ptr_q <= rx_rd_ptr_d;
            rx_cnt_q    <= rx_cnt_d;
            tx_wr_ptr_q <= tx_wr_ptr_d;
            tx_rd_ptr_q <= tx_rd_ptr_d;
            tx_cnt_q    <= tx_cnt_d;
            rd_total_q  <= rd_total_d;
            wr_total_q  <= wr_total_d;
        end
    end

    // Buffer storage; contents are only visible through occupancy, so no reset is needed.
    always_ff @(posedge clk) begin
        if (rx_push) rx_mem_q[rx_wr_ptr_q] <= avm_rd_readdata;
        if (tx_push) tx_mem_q[tx_wr_ptr_q] <= rsp_data;
    end

endmodule

// File: tb/tb_copro_fifo_port.sv
// Self-checking bench for copro_fifo_port: directed scenarios plus random traffic, all checked
// against a queue-based model of the buffers and the read/write traffic rules.
module tb_copro_fifo_port;

    localparam int RXD = 4;
    localparam int TXD = 4;

    logic        clk;
    logic        reset;
    logic        avm_rd_read;
    logic        avm_rd_waitrequest;
    logic [63:0] avm_rd_readdata;
    logic        avm_wr_write;
    logic        avm_wr_waitrequest;
    logic [63:0] avm_wr_writedata;
    logic [63:0] cmd_data;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [63:0] rsp_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic        enable;
    logic        rx_flush;
    logic [31:0] status;

    copro_fifo_port #(.RX_DEPTH(RXD), .TX_DEPTH(TXD)) dut (
        .clk                (clk),
        .reset              (reset),
        .avm_rd_read        (avm_rd_read),
        .avm_rd_waitrequest (avm_rd_waitrequest),
        .avm_rd_readdata    (avm_rd_readdata),
        .avm_wr_write       (avm_wr_write),
        .avm_wr_waitrequest (avm_wr_waitrequest),
        .avm_wr_writedata   (avm_wr_writedata),
        .cmd_data           (cmd_data),
        .cmd_valid          (cmd_valid),
        .cmd_ready          (cmd_ready),
        .rsp_data           (rsp_data),
        .rsp_valid          (rsp_valid),
        .rsp_ready          (rsp_ready),
        .enable             (enable),
        .rx_flush           (rx_flush),
        .status             (status)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model state
    logic [63:0] rxq[$];
    logic [63:0] txq[$];
    bit          m_pend;   // a read request is outstanding
    bit          m_drop;   // outstanding read was hit by a flush
    logic [7:0]  m_acc;
    logic [7:0]  m_wr;

    // Expectations for the current cycle
    logic [163:0] exp_bus;
    bit           exp_acc;
    bit           exp_tpush;
    logic [163:0] rst_bus;

    function automatic logic [163:0] obs_bus();
        return {avm_rd_read, cmd_valid, cmd_data, rsp_ready, avm_wr_write, avm_wr_writedata, status};
    endfunction

    task automatic model_reset();
        rxq.delete();
        txq.delete();
        m_pend = 0;
        m_drop = 0;
        m_acc  = '0;
        m_wr   = '0;
    endtask

    task automatic idle_inputs();
        enable             = 1'b0;
        rx_flush           = 1'b0;
        avm_rd_waitrequest = 1'b0;
        avm_rd_readdata    = '0;
        avm_wr_waitrequest = 1'b0;
        cmd_ready          = 1'b0;
        rsp_valid          = 1'b0;
        rsp_data           = '0;
    endtask

    // Let inputs settle and compute the expected outputs for this cycle.
    task automatic settle();
        logic        cv, wv;
        logic [63:0] cd, wd;
        logic [31:0] st;
        #1;
        cv = (rxq.size() != 0);
        cd = cv ? rxq[0] : 64'h0;
        wv = (txq.size() != 0);
        wd = wv ? txq[0] : 64'h0;
        st = {m_wr, m_acc, 8'(txq.size()), 8'(rxq.size())};
        exp_bus   = {1'(m_pend), cv, cd, 1'(txq.size() < TXD), wv, wd, st};
        exp_acc   = m_pend && !avm_rd_waitrequest;
        exp_tpush = rsp_valid && (txq.size() < TXD);
    endtask

    // Apply this cycle's transfers to the model and move to the next negedge.
    task automatic advance();
        bit acc, pop, push, more, tpop, was_pend;
        acc      = m_pend && !avm_rd_waitrequest;
        pop      = (rxq.size() != 0) && cmd_ready;
        push     = acc && !rx_flush && !m_drop;
        was_pend = m_pend;
        if (acc) m_acc = m_acc + 8'd1;
        if (rx_flush) begin
            rxq.delete();
        end else begin
            if (pop)  void'(rxq.pop_front());
            if (push) rxq.push_back(avm_rd_readdata);
        end
        more = enable && !rx_flush && (rxq.size() < RXD);
        if (!m_pend || acc) m_pend = more;
        if (acc) m_drop = 0;
        else if (rx_flush && was_pend) m_drop = 1;
        tpop = (txq.size() != 0) && !avm_wr_waitrequest;
        if (tpop) begin
            void'(txq.pop_front());
            m_wr = m_wr + 8'd1;
        end
        if (exp_tpush) txq.push_back(rsp_data);
        @(negedge clk);
    endtask

    task automatic apply_reset();
        idle_inputs();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #1 reset = 1'b1;
        #1;
        total++;
        if (obs_bus() !== rst_bus) begin
            bad++;
            $display("FAIL reset_outputs got=%h want=%h", obs_bus(), rst_bus);
        end
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        @(negedge clk);
        total++;
        if (obs_bus() !== rst_bus) begin
            bad++;
            $display("FAIL reset_release got=%h want=%h", obs_bus(), rst_bus);
        end
    endtask

    task automatic test_stream();
        logic [63:0] got[$];
        logic [63:0] seq;
        apply_reset();
        cmd_ready = 1'b1;
        seq = 64'd1;
        for (int c = 0; c < 16; c++) begin
            enable = (seq < 64'd8);
            avm_rd_readdata = seq;
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL stream cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            if (cmd_valid && cmd_ready) got.push_back(cmd_data);
            if (exp_acc) seq++;
            advance();
        end
        total++;
        if (got.size() != 8) begin
            bad++;
            $display("FAIL stream_count got=%0d want=8", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 64'(i + 1)) begin
                bad++;
                $display("FAIL stream_order idx=%0d got=%h want=%h", i, got[i], i + 1);
            end
        end
        total++;
        if (status[23:16] !== 8'd8) begin
            bad++;
            $display("FAIL stream_rdcount got=%0d want=8", status[23:16]);
        end
    endtask

    task automatic test_rx_backpressure();
        logic [63:0] got[$];
        logic [63:0] seq;
        apply_reset();
        enable = 1'b1;
        seq = 64'd1;
        for (int c = 0; c < 10; c++) begin
            avm_rd_readdata = seq;
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL bp_fill cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            if (exp_acc) seq++;
            advance();
        end
        total++;
        if ({avm_rd_read, status[23:16], status[7:0]} !== {1'b0, 8'd4, 8'd4}) begin
            bad++;
            $display("FAIL bp_stall got rd=%b acc=%0d occ=%0d want rd=0 acc=4 occ=4",
                     avm_rd_read, status[23:16], status[7:0]);
        end
        cmd_ready = 1'b1;
        for (int c = 0; c < 20; c++) begin
            enable = (seq < 64'd10);
            avm_rd_readdata = seq;
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL bp_drain cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            if (cmd_valid && cmd_ready) got.push_back(cmd_data);
            if (exp_acc) seq++;
            advance();
        end
        total++;
        if (got.size() != int'(seq - 1)) begin
            bad++;
            $display("FAIL bp_count got=%0d want=%0d", got.size(), seq - 1);
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 64'(i + 1)) begin
                bad++;
                $display("FAIL bp_order idx=%0d got=%h want=%h", i, got[i], i + 1);
            end
        end
    endtask

    task automatic test_read_stall();
        apply_reset();
        enable = 1'b1;
        avm_rd_waitrequest = 1'b1;
        avm_rd_readdata = 64'h5555;
        settle();
        advance();
        for (int k = 0; k < 5; k++) begin
            enable = (k < 2);
            settle();
            total++;
            if (avm_rd_read !== 1'b1 || obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL stall_hold k=%0d got=%h want=%h", k, obs_bus(), exp_bus);
            end
            advance();
        end
        avm_rd_waitrequest = 1'b0;
        for (int c = 0; c < 4; c++) begin
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL stall_release cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            advance();
        end
        total++;
        if ({avm_rd_read, status[23:16], cmd_data} !== {1'b0, 8'd1, 64'h5555}) begin
            bad++;
            $display("FAIL stall_once got rd=%b acc=%0d data=%h want rd=0 acc=1 data=5555",
                     avm_rd_read, status[23:16], cmd_data);
        end
    endtask

    task automatic test_tx_full();
        logic [63:0] got[$];
        logic [63:0] d;
        apply_reset();
        avm_wr_waitrequest = 1'b1;
        rsp_valid = 1'b1;
        d = 64'hA0;
        for (int c = 0; c < 5; c++) begin
            rsp_data = d;
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL txfull_fill cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            if (exp_tpush) d++;
            advance();
        end
        total++;
        if ({rsp_ready, avm_wr_writedata, status[15:8]} !== {1'b0, 64'hA0, 8'd4}) begin
            bad++;
            $display("FAIL txfull_state got rdy=%b data=%h occ=%0d want rdy=0 data=a0 occ=4",
                     rsp_ready, avm_wr_writedata, status[15:8]);
        end
        rsp_valid = 1'b0;
        avm_wr_waitrequest = 1'b0;
        for (int c = 0; c < 6; c++) begin
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL txfull_drain cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            if (avm_wr_write && !avm_wr_waitrequest) got.push_back(avm_wr_writedata);
            advance();
        end
        total++;
        if (got.size() != 4) begin
            bad++;
            $display("FAIL txfull_count got=%0d want=4", got.size());
        end
        for (int i = 0; i < got.size(); i++) begin
            total++;
            if (got[i] !== 64'(8'hA0 + i)) begin
                bad++;
                $display("FAIL txfull_order idx=%0d got=%h want=%h", i, got[i], 8'hA0 + i);
            end
        end
        total++;
        if (status[31:24] !== 8'd4) begin
            bad++;
            $display("FAIL txfull_wrcount got=%0d want=4", status[31:24]);
        end
    endtask

    task automatic test_flush();
        apply_reset();
        for (int c = 0; c < 8; c++) begin
            enable             = (c < 3);
            avm_rd_waitrequest = (c >= 3 && c <= 5);
            rx_flush           = (c == 4);
            avm_rd_readdata    = 64'hF00 + 64'(c);
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL flush cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            if (c == 4 && status[7:0] !== 8'd2) begin
                bad++;
                $display("FAIL flush_pre occ got=%0d want=2", status[7:0]);
            end
            if (c == 5 && {cmd_valid, avm_rd_read} !== 2'b01) begin
                bad++;
                $display("FAIL flush_after got valid=%b rd=%b want valid=0 rd=1",
                         cmd_valid, avm_rd_read);
            end
            advance();
        end
        total++;
        if ({cmd_valid, avm_rd_read, status[7:0], status[23:16]} !== {1'b0, 1'b0, 8'd0, 8'd3}) begin
            bad++;
            $display("FAIL flush_discard got valid=%b rd=%b occ=%0d acc=%0d want 0 0 0 3",
                     cmd_valid, avm_rd_read, status[7:0], status[23:16]);
        end
    endtask

    task automatic test_random();
        apply_reset();
        for (int c = 0; c < 1500; c++) begin
            enable             = ($urandom_range(0, 3) != 0);
            avm_rd_waitrequest = ($urandom_range(0, 2) == 0);
            avm_rd_readdata    = {$urandom, $urandom};
            cmd_ready          = ($urandom_range(0, 1) == 0);
            rsp_valid          = ($urandom_range(0, 1) == 0);
            rsp_data           = {$urandom, $urandom};
            avm_wr_waitrequest = ($urandom_range(0, 2) == 0);
            rx_flush           = ($urandom_range(0, 24) == 0);
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL random cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            advance();
        end
    endtask

    task automatic test_async_reset();
        apply_reset();
        enable = 1'b1;
        rsp_valid = 1'b1;
        avm_wr_waitrequest = 1'b1;
        for (int c = 0; c < 6; c++) begin
            avm_rd_readdata = 64'hC0 + 64'(c);
            rsp_data = 64'hD0 + 64'(c);
            settle();
            total++;
            if (obs_bus() !== exp_bus) begin
                bad++;
                $display("FAIL areset_fill cyc=%0d got=%h want=%h", c, obs_bus(), exp_bus);
            end
            advance();
        end
        total++;
        if (status[7:0] === 8'd0 || status[15:8] === 8'd0) begin
            bad++;
            $display("FAIL areset_pre got status=%h want both occupancies nonzero", status);
        end
        #2 reset = 1'b1;
        #1;
        total++;
        if (obs_bus() !== rst_bus) begin
            bad++;
            $display("FAIL areset_outputs got=%h want=%h", obs_bus(), rst_bus);
        end
        @(negedge clk);
        reset = 1'b0;
        model_reset();
        idle_inputs();
    endtask

    initial begin
        rst_bus = {1'b0, 1'b0, 64'h0, 1'b1, 1'b0, 64'h0, 32'h0};
        model_reset();
        test_reset();
        test_stream();
        test_rx_backpressure();
        test_read_stall();
        test_tx_full();
        test_flush();
        test_random();
        test_async_reset();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog expired");
        $fatal(1);
    end

endmodule

// File: doc/copro_fifo_port.md
# copro_fifo_port

Coprocessor-side endpoint for the two 64-bit HPS↔FPGA Avalon-MM FIFO channels exported by the `soc_system` platform. The block acts as Avalon-MM master on both channels:
- It pops command words from the HPS→coprocessor FIFO (`fifo_to_copro_out`) and presents them as a valid/ready stream to the accelerator.
- It pushes accelerator result words into the coprocessor→HPS FIFO (`fifo_to_hps_in`).
- It drives a 32-bit status word that feeds `pio_status_export`.

## Interface

Parameters:
- `RX_DEPTH`, default 4: entries in the command buffer; power of two, 2..128.
- `TX_DEPTH`, default 4: entries in the result buffer; power of two, 2..128.

Ports:
- `clk`  in  1  single clock (the platform's 95 MHz `clock_95_clk` domain).
- `reset`  in  1  asynchronous, active-high reset.
- `avm_rd_read`  out  1  read request to `fifo_to_copro_out`.
- `avm_rd_waitrequest`  in  1  read stall from the FIFO.
- `avm_rd_readdata`  in  64  read data from the FIFO.
- `avm_wr_write`  out  1  write request to `fifo_to_hps_in`.
- `avm_wr_waitrequest`  in  1  write stall from the FIFO.
- `avm_wr_writedata`  out  64  write data to the FIFO.
- `cmd_data`  out  64  command word to the accelerator.
- `cmd_valid`  out  1  command word available.
- `cmd_ready`  in  1  accelerator accepts the command word.
- `rsp_data`  in  64  result word from the accelerator.
- `rsp_valid`  in  1  result word offered.
- `rsp_ready`  out  1  block accepts the result word.
- `enable`  in  1  permits new reads from the HPS FIFO.
- `rx_flush`  in  1  synchronous discard of the command buffer.
- `status`  out  32  status word; drive to `pio_status_export`.

## Operation

Read engine, two states: `RD_IDLE` and `RD_REQ`. `avm_rd_read` is a registered output and equals (state == `RD_REQ`).
- Acceptance: a read is accepted in any cycle where `avm_rd_read && !avm_rd_waitrequest`. `avm_rd_readdata` is valid in that same cycle (zero read latency) and is pushed into the RX buffer.
- Define `rx_next` as the RX occupancy after this cycle's push and pop.
- `RD_IDLE` → `RD_REQ` when `enable && !rx_flush && rx_next < RX_DEPTH`.
- `RD_REQ` with waitrequest high: remain in `RD_REQ`. The read is held regardless of `enable` or `rx_flush`, as Avalon requires.
- `RD_REQ` on acceptance: remain in `RD_REQ` if `enable && !rx_flush && rx_next < RX_DEPTH`, otherwise go to `RD_IDLE`.
- A slot is reserved on entry to `RD_REQ`, so the RX buffer never overflows.

RX buffer (circular, `RX_DEPTH` entries):
- `cmd_valid` = occupancy ≠ 0; `cmd_data` = head entry.
- Pop on `cmd_valid && cmd_ready`. Push and pop may occur in the same cycle.
- `rx_flush`: occupancy and pointers cleared at the next edge. A word accepted from the HPS FIFO in the flush cycle is discarded. The flush is not counted as a pop.

TX buffer (circular, `TX_DEPTH` entries):
- `rsp_ready` = occupancy < `TX_DEPTH`. It is derived from registered state only, so there is no combinational path from `rsp_valid` or `avm_wr_waitrequest`.
- Push on `rsp_valid && rsp_ready`.
- `avm_wr_write` = occupancy ≠ 0; `avm_wr_writedata` = head entry.
- Pop on `avm_wr_write && !avm_wr_waitrequest`. The head, and therefore the write data, stays stable while stalled.
- When full, a same-cycle pop does not raise `rsp_ready` until the next cycle.

Status word:
- [7:0] RX occupancy.
- [15:8] TX occupancy.
- [23:16] count of words accepted from the HPS FIFO, modulo 256, wrapping.
- [31:24] count of words written to the HPS FIFO, modulo 256, wrapping.
- Occupancy fields are zero-extended. Counters are not cleared by `rx_flush`.

## Timing

- Reset (asynchronous, active-high): state `RD_IDLE`, both buffers empty, counters 0. Resulting outputs:
  - `avm_rd_read` = 0, `avm_wr_write` = 0, `avm_wr_writedata` = 0.
  - `cmd_valid` = 0, `cmd_data` = 0.
  - `rsp_ready` = 1 from the first cycle after reset release; `status` = 0.
- Reset asserted mid-transfer: in-flight state is abandoned immediately and buffered words are lost.
- Read issue latency: `enable` high at edge N → `avm_rd_read` high after edge N+1.
- Command latency: read accepted at edge N → `cmd_valid` high after edge N+1.
- Result latency: `rsp_valid && rsp_ready` at edge N → `avm_wr_write` high after edge N+1.
- Throughput: one word per cycle per direction when not stalled and `RX_DEPTH` ≥ 2.

## Test plan

- **Stream through:** reset, `enable`=1, `waitrequest`=0, `cmd_ready`=1, readdata sequence 0x1..0x8 → `cmd_data` delivers 0x1..0x8 in order, one per cycle, each one cycle after acceptance; `status[23:16]` = 8.
- **RX backpressure:** `cmd_ready`=0 with default depth → exactly 4 reads accepted, then `avm_rd_read` drops. Raising `cmd_ready` resumes reads; no word is lost or duplicated.
- **Read stall + enable drop:** hold `avm_rd_waitrequest`=1 for 5 cycles and drop `enable` in cycle 2 → `avm_rd_read` stays high until acceptance. Exactly one word is accepted, then the engine returns to `RD_IDLE`.
- **TX full + write stall:** `avm_wr_waitrequest`=1, push 0xA0..0xA4 → 4 accepted and `rsp_ready`=0. `avm_wr_writedata` holds 0xA0 stable. Releasing the stall writes 0xA0..0xA3 in order; `status[31:24]` = 4.
- **Flush during pending read:** RX holds 2 words, read stalled, `rx_flush` pulsed → `cmd_valid`=0 next cycle. The stalled read completes and its word is discarded; `status[7:0]` = 0.
- **Async reset mid-operation:** assert `reset` while both buffers are non-empty → all outputs take their reset values without a clock edge.
